// File: rtl/counter_display_bank.sv
// counter_display_bank
//   Bank of NUM_DISPLAYS multi-digit up/down counters, one per seven_segment
//   driver. Each counter has its own HEX/DEC mode, a sticky overflow flag and
//   leading-zero blanking. A shared hold-to-auto-repeat FSM turns a held button
//   into a stream of steps.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   button_down  single-cycle press pulse from the debouncer (one step)
//   button_held  debounced level, high while the button is pressed
//   sel          counter targeted by steps and clear
//   up_dn        1: increment, 0: decrement
//   dec_mode     per counter: 1 = BCD digits, 0 = hex digits
//   clear        zero counter sel and its overflow flag
//   encoded      digit values per counter, digit 0 = least significant
//   digit_point  decimal point enables, only the MSD shows overflow
//   blank        1 = leading zero that the display should blank
//   overflow     sticky wrap/saturate flag per counter
//
// Repeat FSM
//   state    | meaning
//   S_IDLE   | button released, no auto-repeat pending
//   S_ARMED  | button pressed, timer counting down the hold delay
//   S_REPEAT | hold delay elapsed, one step each time the timer reaches zero
module counter_display_bank #(
  parameter int NUM_DISPLAYS  = 2,
  parameter int NUM_DIGITS    = 4,
  parameter int WRAP          = 1,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  localparam int SEL_W = (NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       button_down,
  input  logic                                       button_held,
  input  logic [SEL_W-1:0]                           sel,
  input  logic                                       up_dn,
  input  logic [NUM_DISPLAYS-1:0]                    dec_mode,
  input  logic                                       clear,
  output logic [NUM_DISPLAYS-1:0][NUM_DIGITS-1:0][3:0] encoded,
  output logic [NUM_DISPLAYS-1:0][NUM_DIGITS-1:0]    digit_point,
  output logic [NUM_DISPLAYS-1:0][NUM_DIGITS-1:0]    blank,
  output logic [NUM_DISPLAYS-1:0]                    overflow
);

  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LOAD  = TMR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_REPEAT} rpt_state_t;

  rpt_state_t       rpt_state;
  logic [TMR_W-1:0] rpt_timer;
  logic             rpt_tick;
  logic             step;

  logic [NUM_DISPLAYS-1:0][NUM_DIGITS-1:0][3:0] count;
  logic [NUM_DISPLAYS-1:0][NUM_DIGITS-1:0][3:0] count_inc;
  logic [NUM_DISPLAYS-1:0][NUM_DIGITS-1:0][3:0] count_dec;
  logic [NUM_DISPLAYS-1:0] dec_q;
  logic [NUM_DISPLAYS-1:0] mode_chg;
  logic [NUM_DISPLAYS-1:0] hit;
  logic [NUM_DISPLAYS-1:0] at_max;
  logic [NUM_DISPLAYS-1:0] at_min;

  // The tick depends on the live button level so a release never produces
  // a step in the release cycle.
  assign rpt_tick = (rpt_state == S_REPEAT) && button_held && (rpt_timer == '0);
  assign step     = button_down || rpt_tick;
  assign mode_chg = dec_mode ^ dec_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_state <= S_IDLE;
      rpt_timer <= '0;
    end else if (button_down) begin
      // A fresh press always restarts the hold delay.
      rpt_state <= S_ARMED;
      rpt_timer <= HOLD_LOAD;
    end else if (!button_held) begin
      rpt_state <= S_IDLE;
      rpt_timer <= '0;
    end else begin
      case (rpt_state)
        S_ARMED: begin
          if (rpt_timer == '0) begin
            rpt_state <= S_REPEAT;
            rpt_timer <= '0;
          end else begin
            rpt_timer <= rpt_timer - TMR_W'(1);
          end
        end
        S_REPEAT: begin
          if (rpt_timer == '0) rpt_timer <= REP_LOAD;
          else                 rpt_timer <= rpt_timer - TMR_W'(1);
        end
        default: begin
          rpt_state <= S_IDLE;
          rpt_timer <= '0;
        end
      endcase
    end
  end

  // An out-of-range sel matches no counter, so steps and clear are dropped.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_DISPLAYS; i++) begin
      hit[i] = (sel == SEL_W'(i));
    end
  end

  // Ripple carry/borrow across all digits. A carry (borrow) surviving past
  // the MSD means the counter was at max (zero); the rippled value is then
  // already the wrapped result.
  always_comb begin
    logic [3:0] dmax;
    logic       carry;
    logic       borrow;
    count_inc = count;
    count_dec = count;
    at_max    = '0;
    at_min    = '0;
    dmax      = 4'd0;
    carry     = 1'b0;
    borrow    = 1'b0;
    for (int i = 0; i < NUM_DISPLAYS; i++) begin
      dmax   = dec_q[i] ? 4'd9 : 4'd15;
      carry  = 1'b1;
      borrow = 1'b1;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (carry) begin
          if (count[i][d] == dmax) begin
            count_inc[i][d] = 4'd0;
          end else begin
            count_inc[i][d] = count[i][d] + 4'd1;
            carry = 1'b0;
          end
        end
        if (borrow) begin
          if (count[i][d] == 4'd0) begin
            count_dec[i][d] = dmax;
          end else begin
            count_dec[i][d] = count[i][d] - 4'd1;
            borrow = 1'b0;
          end
        end
      end
      at_max[i] = carry;
      at_min[i] = borrow;
    end
  end

  // Priority per counter: mode change, then clear, then step.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      overflow <= '0;
      dec_q    <= dec_mode;
    end else begin
      dec_q <= dec_mode;
      for (int i = 0; i < NUM_DISPLAYS; i++) begin
        if (mode_chg[i] || (clear && hit[i])) begin
          count[i]    <= '0;
          overflow[i] <= 1'b0;
        end else if (step && hit[i]) begin
          if (up_dn) begin
            if (!at_max[i] || (WRAP != 0)) count[i] <= count_inc[i];
            if (at_max[i]) overflow[i] <= 1'b1;
          end else begin
            if (!at_min[i] || (WRAP != 0)) count[i] <= count_dec[i];
            if (at_min[i]) overflow[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign encoded = count;

  always_comb begin
    logic upper_zero;
    blank       = '0;
    digit_point = '0;
    upper_zero  = 1'b1;
    for (int i = 0; i < NUM_DISPLAYS; i++) begin
      upper_zero = 1'b1;
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
        upper_zero  = upper_zero && (count[i][d] == 4'd0);
        blank[i][d] = upper_zero && (d != 0);
      end
      digit_point[i][NUM_DIGITS-1] = overflow[i];
    end
  end

endmodule

// File: tb/tb_counter_display_bank.sv
module tb_counter_display_bank;

  localparam int ND   = 2;
  localparam int NG   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic reset, button_down, button_held, up_dn, clear;
  logic [0:0] sel;
  logic [ND-1:0] dec_mode;

  logic [ND-1:0][NG-1:0][3:0] enc_w, enc_s;
  logic [ND-1:0][NG-1:0]      dp_w, dp_s, blank_w, blank_s;
  logic [ND-1:0]              ov_w, ov_s;

  int checks = 0;
  int errors = 0;

  // Reference model: counts as plain integers, index 0 = wrap DUT, 1 = saturate DUT.
  int          cnt [2][ND];
  bit          ovm [2][ND];
  logic [ND-1:0] mode_q = '0;
  int          age = -1;   // cycles since the last press while held, -1 when released

  always #5 clk = ~clk;

  counter_display_bank #(
    .NUM_DISPLAYS(ND), .NUM_DIGITS(NG), .WRAP(1),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_wrap (
    .clk(clk), .reset(reset), .button_down(button_down), .button_held(button_held),
    .sel(sel), .up_dn(up_dn), .dec_mode(dec_mode), .clear(clear),
    .encoded(enc_w), .digit_point(dp_w), .blank(blank_w), .overflow(ov_w)
  );

  counter_display_bank #(
    .NUM_DISPLAYS(ND), .NUM_DIGITS(NG), .WRAP(0),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_sat (
    .clk(clk), .reset(reset), .button_down(button_down), .button_held(button_held),
    .sel(sel), .up_dn(up_dn), .dec_mode(dec_mode), .clear(clear),
    .encoded(enc_s), .digit_point(dp_s), .blank(blank_s), .overflow(ov_s)
  );

  function automatic int max_val(logic dec);
    int p = 1;
    for (int d = 0; d < NG; d++) p = p * (dec ? 10 : 16);
    return p - 1;
  endfunction

  function automatic logic [NG-1:0][3:0] to_digits(int v, logic dec);
    logic [NG-1:0][3:0] res;
    int base = dec ? 10 : 16;
    int r = v;
    for (int d = 0; d < NG; d++) begin
      res[d] = 4'(r % base);
      r = r / base;
    end
    return res;
  endfunction

  function automatic logic [NG-1:0] blank_of(int v, logic dec);
    logic [NG-1:0] res;
    int base = dec ? 10 : 16;
    int p = 1;
    for (int d = 0; d < NG; d++) begin
      res[d] = (d != 0) && (v < p);
      p = p * base;
    end
    return res;
  endfunction

  function automatic logic [ND-1:0][NG-1:0][3:0] exp_enc(int v);
    logic [ND-1:0][NG-1:0][3:0] res;
    for (int i = 0; i < ND; i++) res[i] = to_digits(cnt[v][i], mode_q[i]);
    return res;
  endfunction

  function automatic logic [ND-1:0][NG-1:0] exp_blank(int v);
    logic [ND-1:0][NG-1:0] res;
    for (int i = 0; i < ND; i++) res[i] = blank_of(cnt[v][i], mode_q[i]);
    return res;
  endfunction

  function automatic logic [ND-1:0][NG-1:0] exp_dp(int v);
    logic [ND-1:0][NG-1:0] res;
    for (int i = 0; i < ND; i++) res[i] = {ovm[v][i], {(NG-1){1'b0}}};
    return res;
  endfunction

  function automatic logic [ND-1:0] exp_ov(int v);
    logic [ND-1:0] res;
    for (int i = 0; i < ND; i++) res[i] = ovm[v][i];
    return res;
  endfunction

  task automatic model_step();
    bit tick = 0;
    bit stp;
    int m;
    if (reset) begin
      for (int v = 0; v < 2; v++)
        for (int i = 0; i < ND; i++) begin
          cnt[v][i] = 0;
          ovm[v][i] = 0;
        end
      mode_q = dec_mode;
      age = -1;
      return;
    end
    if (button_down) age = 0;
    else if (age >= 0 && button_held) begin
      age++;
      if (age >= HOLD + 1 && ((age - HOLD - 1) % REP) == 0) tick = 1;
    end else age = -1;
    stp = button_down || tick;
    for (int i = 0; i < ND; i++) begin
      for (int v = 0; v < 2; v++) begin
        if (dec_mode[i] != mode_q[i] || (clear && int'(sel) == i)) begin
          cnt[v][i] = 0;
          ovm[v][i] = 0;
        end else if (stp && int'(sel) == i) begin
          m = max_val(mode_q[i]);
          if (up_dn) begin
            if (cnt[v][i] == m) begin
              ovm[v][i] = 1;
              if (v == 0) cnt[v][i] = 0;
            end else cnt[v][i]++;
          end else begin
            if (cnt[v][i] == 0) begin
              ovm[v][i] = 1;
              if (v == 0) cnt[v][i] = m;
            end else cnt[v][i]--;
          end
        end
      end
    end
    mode_q = dec_mode;
  endtask

  // One clock: the model consumes the inputs seen at the edge, outputs are
  // sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse(input logic [0:0] s, input logic dir);
    sel = s; up_dn = dir; button_down = 1; button_held = 1;
    cyc();
    button_down = 0; button_held = 0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1;
    cyc(); cyc();
    checks++; if (enc_w !== '0) begin errors++; $display("FAIL reset_enc_w got=%h exp=0", enc_w); end
    checks++; if (enc_s !== '0) begin errors++; $display("FAIL reset_enc_s got=%h exp=0", enc_s); end
    checks++; if (blank_w !== 8'hEE) begin errors++; $display("FAIL reset_blank got=%b exp=11101110", blank_w); end
    checks++; if (dp_w !== '0 || dp_s !== '0) begin errors++; $display("FAIL reset_dp got=%b/%b exp=0", dp_w, dp_s); end
    checks++; if (ov_w !== '0 || ov_s !== '0) begin errors++; $display("FAIL reset_ov got=%b/%b exp=0", ov_w, ov_s); end
    reset = 0;
    cyc();
  endtask

  task automatic test_count_dec();
    dec_mode = 2'b11;
    cyc();
    repeat (12) pulse(1'b0, 1'b1);
    checks++; if (enc_w[0] !== 16'h0012) begin errors++; $display("FAIL dec12_enc got=%h exp=0012", enc_w[0]); end
    checks++; if (blank_w[0] !== 4'b1100) begin errors++; $display("FAIL dec12_blank got=%b exp=1100", blank_w[0]); end
    checks++; if (enc_w[1] !== 16'h0000) begin errors++; $display("FAIL dec12_other got=%h exp=0000", enc_w[1]); end
    checks++; if (enc_s[0] !== 16'h0012) begin errors++; $display("FAIL dec12_sat got=%h exp=0012", enc_s[0]); end
  endtask

  task automatic test_wrap_dec();
    sel = 0; clear = 1;
    cyc();
    clear = 0;
    checks++; if (enc_w[0] !== 16'h0) begin errors++; $display("FAIL clear_enc got=%h exp=0000", enc_w[0]); end
    // Back-to-back presses keep restarting the hold delay, so no auto-repeat.
    up_dn = 1; button_down = 1; button_held = 1;
    repeat (9999) cyc();
    button_down = 0; button_held = 0;
    cyc();
    checks++; if (enc_w[0] !== 16'h9999 || ov_w[0] !== 1'b0) begin errors++; $display("FAIL preload_9999 got=%h ov=%b exp=9999 ov=0", enc_w[0], ov_w[0]); end
    pulse(1'b0, 1'b1);
    checks++; if (enc_w[0] !== 16'h0000) begin errors++; $display("FAIL wrap_up_enc got=%h exp=0000", enc_w[0]); end
    checks++; if (ov_w[0] !== 1'b1 || dp_w[0] !== 4'b1000) begin errors++; $display("FAIL wrap_up_ov got=%b dp=%b exp=1 dp=1000", ov_w[0], dp_w[0]); end
    checks++; if (enc_s[0] !== 16'h9999 || ov_s[0] !== 1'b1) begin errors++; $display("FAIL sat_up got=%h ov=%b exp=9999 ov=1", enc_s[0], ov_s[0]); end
    checks++; if (dp_s[0] !== 4'b1000) begin errors++; $display("FAIL sat_up_dp got=%b exp=1000", dp_s[0]); end
    checks++; if (enc_w[1] !== 16'h0 || ov_w[1] !== 1'b0) begin errors++; $display("FAIL wrap_other got=%h ov=%b exp=0000 ov=0", enc_w[1], ov_w[1]); end
  endtask

  task automatic test_hex_down();
    dec_mode[0] = 0;
    cyc();
    checks++; if (enc_w[0] !== 16'h0 || ov_w[0] !== 1'b0 || ov_s[0] !== 1'b0) begin errors++; $display("FAIL mode0_zero got=%h ov=%b/%b exp=0000 ov=0", enc_w[0], ov_w[0], ov_s[0]); end
    pulse(1'b0, 1'b0);
    checks++; if (enc_w[0] !== 16'hFFFF || ov_w[0] !== 1'b1) begin errors++; $display("FAIL hex_down got=%h ov=%b exp=ffff ov=1", enc_w[0], ov_w[0]); end
    checks++; if (enc_s[0] !== 16'h0 || ov_s[0] !== 1'b1) begin errors++; $display("FAIL hex_down_sat got=%h ov=%b exp=0000 ov=1", enc_s[0], ov_s[0]); end
    pulse(1'b0, 1'b1);
    checks++; if (enc_w[0] !== 16'h0 || enc_s[0] !== 16'h1) begin errors++; $display("FAIL hex_up got=%h/%h exp=0000/0001", enc_w[0], enc_s[0]); end
  endtask

  task automatic test_mode_change();
    dec_mode[1] = 0;
    cyc();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    sel = 1; up_dn = 1; button_down = 1; button_held = 1;
    repeat (255) cyc();
    button_down = 0; button_held = 0;
    cyc();
    checks++; if (enc_w[1] !== 16'h00FF || ov_w[1] !== 1'b1) begin errors++; $display("FAIL hex_00ff got=%h ov=%b exp=00ff ov=1", enc_w[1], ov_w[1]); end
    checks++; if (blank_w[1] !== 4'b1100) begin errors++; $display("FAIL hex_00ff_blank got=%b exp=1100", blank_w[1]); end
    // Toggle together with a step on the same counter: the mode change wins.
    dec_mode[1] = 1; sel = 1; button_down = 1; button_held = 1;
    cyc();
    button_down = 0; button_held = 0;
    checks++; if (enc_w[1] !== 16'h0 || ov_w[1] !== 1'b0) begin errors++; $display("FAIL mode_toggle got=%h ov=%b exp=0000 ov=0", enc_w[1], ov_w[1]); end
    checks++; if (enc_s[0] !== 16'h1) begin errors++; $display("FAIL mode_toggle_other got=%h exp=0001", enc_s[0]); end
    cyc();
  endtask

  task automatic test_auto_repeat();
    int expv;
    sel = 0; clear = 1;
    cyc();
    clear = 0;
    up_dn = 1; button_down = 1; button_held = 1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      button_down = 0;
      expv = 1 + ((c >= 9) ? 1 : 0) + ((c >= 13) ? 1 : 0) + ((c >= 17) ? 1 : 0);
      checks++; if (enc_w[0] !== 16'(expv)) begin errors++; $display("FAIL repeat_c%0d got=%h exp=%h", c, enc_w[0], 16'(expv)); end
    end
    button_held = 0;
    repeat (10) cyc();
    checks++; if (enc_w[0] !== 16'h4 || enc_s[0] !== 16'h4) begin errors++; $display("FAIL repeat_release got=%h/%h exp=0004", enc_w[0], enc_s[0]); end
  endtask

  task automatic test_clear_wins();
    sel = 0; up_dn = 1; clear = 1; button_down = 1; button_held = 1;
    cyc();
    clear = 0; button_down = 0; button_held = 0;
    checks++; if (enc_w[0] !== 16'h0 || enc_s[0] !== 16'h0) begin errors++; $display("FAIL clear_wins got=%h/%h exp=0000", enc_w[0], enc_s[0]); end
    cyc();
  endtask

  task automatic test_reset_mid_repeat();
    pulse(1'b1, 1'b0);
    sel = 0; up_dn = 1; button_down = 1; button_held = 1;
    cyc();
    button_down = 0;
    repeat (11) cyc();
    checks++; if (enc_w[0] !== 16'h2) begin errors++; $display("FAIL pre_reset_repeat got=%h exp=0002", enc_w[0]); end
    reset = 1;
    cyc();
    reset = 0;
    checks++; if (enc_w !== '0 || enc_s !== '0) begin errors++; $display("FAIL midrep_enc got=%h/%h exp=0", enc_w, enc_s); end
    checks++; if (blank_w !== 8'hEE || blank_s !== 8'hEE) begin errors++; $display("FAIL midrep_blank got=%b/%b exp=11101110", blank_w, blank_s); end
    checks++; if (ov_w !== '0 || dp_w !== '0) begin errors++; $display("FAIL midrep_ov got=%b dp=%b exp=0", ov_w, dp_w); end
    repeat (10) cyc();
    checks++; if (enc_w !== '0 || enc_s !== '0) begin errors++; $display("FAIL midrep_noticks got=%h/%h exp=0", enc_w, enc_s); end
    button_held = 0;
    cyc();
  endtask

  task automatic test_random();
    logic [ND-1:0][NG-1:0][3:0] ge;
    logic [ND-1:0][NG-1:0]      gb, gd;
    logic [ND-1:0]              go;
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 19) == 0) begin
        button_down = 1; button_held = 1;
      end else begin
        button_down = 0;
        if ($urandom_range(0, 39) == 0) button_held = 0;
      end
      sel   = 1'($urandom_range(0, 1));
      up_dn = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < ND; i++)
        if ($urandom_range(0, 59) == 0) dec_mode[i] = ~dec_mode[i];
      cyc();
      for (int v = 0; v < 2; v++) begin
        ge = (v == 0) ? enc_w : enc_s;
        gb = (v == 0) ? blank_w : blank_s;
        gd = (v == 0) ? dp_w : dp_s;
        go = (v == 0) ? ov_w : ov_s;
        checks++; if (ge !== exp_enc(v)) begin errors++; $display("FAIL rnd_enc v%0d n%0d got=%h exp=%h", v, n, ge, exp_enc(v)); end
        checks++; if (gb !== exp_blank(v)) begin errors++; $display("FAIL rnd_blank v%0d n%0d got=%b exp=%b", v, n, gb, exp_blank(v)); end
        checks++; if (gd !== exp_dp(v)) begin errors++; $display("FAIL rnd_dp v%0d n%0d got=%b exp=%b", v, n, gd, exp_dp(v)); end
        checks++; if (go !== exp_ov(v)) begin errors++; $display("FAIL rnd_ov v%0d n%0d got=%b exp=%b", v, n, go, exp_ov(v)); end
      end
    end
    reset = 0; button_down = 0; button_held = 0; clear = 0;
    cyc();
  endtask

  initial begin
    reset = 1; button_down = 0; button_held = 0; sel = 0; up_dn = 1;
    clear = 0; dec_mode = '0;
    for (int v = 0; v < 2; v++)
      for (int i = 0; i < ND; i++) begin
        cnt[v][i] = 0;
        ovm[v][i] = 0;
      end
    test_reset();
    test_count_dec();
    test_wrap_dec();
    test_hex_down();
    test_mode_change();
    test_auto_repeat();
    test_clear_wins();
    test_reset_mid_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
